// File: rtl/ha1588_pkg.sv
// Shared definitions for the ha1588 local-bus arbiter: FSM state encoding
// and the read-latency limit that sizes the WAIT counter.
package ha1588_pkg;

    localparam int unsigned RD_LAT_MAX = 7;
    localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ha1588_rr_arb.sv
// Two-way round-robin picker with lock.
// Ports:
//   i_req0/i_req1 : requests from requester 0 / 1
//   i_prio        : requester holding priority when both request
//   i_lock        : bus is locked to i_lock_id; the other requester is ignored
//   i_lock_id     : current lock owner
//   o_valid_c     : a requester is selected (combinational)
//   o_id_c        : selected requester (combinational)
module ha1588_rr_arb (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    input  logic i_lock,
    input  logic i_lock_id,
    output logic o_valid_c,
    output logic o_id_c
);

    always_comb begin
        o_valid_c = 1'b0;
        o_id_c    = 1'b0;
        if (i_lock) begin
            // Locked: only the owner may be served, even if it is idle.
            o_id_c    = i_lock_id;
            o_valid_c = i_lock_id ? i_req1 : i_req0;
        end else if (i_req0 && i_req1) begin
            o_valid_c = 1'b1;
            o_id_c    = i_prio;
        end else begin
            o_valid_c = i_req0 | i_req1;
            o_id_c    = i_req1;
        end
    end

endmodule

// File: rtl/ha1588_bus_arb.sv
// Arbitrates two local-bus masters onto the single ha1588 core register port.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   mN_req/we/addr/wdata/lock      : requester N transaction and lock request
//   mN_gnt/ack/rdata               : requester N grant, completion pulse, read data
//   up_wr/up_rd/up_addr/up_data_wr : one-cycle strobes and payload to the core
//   up_data_rd                     : core read data, valid RD_LAT cycles after up_rd
//   busy                           : transaction in progress
module ha1588_bus_arb
    import ha1588_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              up_wr,
    output logic              up_rd,
    output logic [ADDR_W-1:0] up_addr,
    output logic [DATA_W-1:0] up_data_wr,
    input  logic [DATA_W-1:0] up_data_rd,
    output logic              busy
);

    state_t              r_state;
    logic                r_owner;
    logic                r_we;
    logic                r_prio;
    logic                r_lock;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_m0_gnt;
    logic                r_m1_gnt;
    logic                r_m0_ack;
    logic                r_m1_ack;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_up_wr;
    logic                r_up_rd;
    logic [ADDR_W-1:0]   r_up_addr;
    logic [DATA_W-1:0]   r_up_wdata;
    logic                r_busy;

    logic                w_pick_vld;
    logic                w_pick_id;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_own_lock;

    ha1588_rr_arb u_rr_arb (
        .i_req0    (m0_req),
        .i_req1    (m1_req),
        .i_prio    (r_prio),
        .i_lock    (r_lock),
        .i_lock_id (r_owner),
        .o_valid_c (w_pick_vld),
        .o_id_c    (w_pick_id)
    );

    // Payload of the requester being picked this cycle.
    assign w_we       = w_pick_id ? m1_we    : m0_we;
    assign w_addr     = w_pick_id ? m1_addr  : m0_addr;
    assign w_wdata    = w_pick_id ? m1_wdata : m0_wdata;
    assign w_own_lock = r_owner   ? m1_lock  : m0_lock;

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_prio     <= 1'b0;
            r_lock     <= 1'b0;
            r_cnt      <= '0;
            r_m0_gnt   <= 1'b0;
            r_m1_gnt   <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_up_wr    <= 1'b0;
            r_up_rd    <= 1'b0;
            r_up_addr  <= '0;
            r_up_wdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_up_wr  <= 1'b0;
            r_up_rd  <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_state    <= ST_ISSUE;
                        r_busy     <= 1'b1;
                        r_owner    <= w_pick_id;
                        r_we       <= w_we;
                        r_up_addr  <= w_addr;
                        r_up_wdata <= w_wdata;
                        r_up_wr    <= w_we;
                        r_up_rd    <= ~w_we;
                        r_m0_gnt   <= ~w_pick_id;
                        r_m1_gnt   <= w_pick_id;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_state  <= ST_DONE;
                        r_m0_ack <= ~r_owner;
                        r_m1_ack <= r_owner;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CNT_W'(RD_LAT - 1);
                    end
                end
                ST_WAIT: begin
                    // Last WAIT cycle is exactly RD_LAT cycles after up_rd.
                    if (r_cnt == '0) begin
                        r_state  <= ST_DONE;
                        r_m0_ack <= ~r_owner;
                        r_m1_ack <= r_owner;
                        if (r_owner) begin
                            r_m1_rdata <= up_data_rd;
                        end else begin
                            r_m0_rdata <= up_data_rd;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_lock  <= w_own_lock;
                    // An unlocked completion releases the bus and passes priority.
                    if (!w_own_lock) begin
                        r_prio   <= ~r_owner;
                        r_m0_gnt <= 1'b0;
                        r_m1_gnt <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m0_gnt     = r_m0_gnt;
    assign m1_gnt     = r_m1_gnt;
    assign m0_ack     = r_m0_ack;
    assign m1_ack     = r_m1_ack;
    assign m0_rdata   = r_m0_rdata;
    assign m1_rdata   = r_m1_rdata;
    assign up_wr      = r_up_wr;
    assign up_rd      = r_up_rd;
    assign up_addr    = r_up_addr;
    assign up_data_wr = r_up_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ha1588_bus_arb.sv
// Bench for ha1588_bus_arb: a transaction-schedule model checked every cycle
// against the RD_LAT=1 instance, plus directed checks on an RD_LAT=3 instance.
module tb_ha1588_bus_arb;

    localparam int unsigned LAT = 1;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        lock;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [7:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [7:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        up_wr, up_rd, busy;
    logic [7:0]  up_addr;
    logic [31:0] up_data_wr;
    logic [31:0] up_data_rd = 32'hDEAD_BEEF;

    logic        d3_m0_req = 1'b0, d3_m0_we = 1'b0;
    logic [7:0]  d3_m0_addr = '0;
    logic [31:0] d3_m0_wdata = '0;
    logic        d3_zero = 1'b0;
    logic [7:0]  d3_zaddr = '0;
    logic [31:0] d3_zdata = '0;
    logic        d3_m0_gnt, d3_m0_ack, d3_m1_gnt, d3_m1_ack;
    logic [31:0] d3_m0_rdata, d3_m1_rdata;
    logic        d3_up_wr, d3_up_rd, d3_busy;
    logic [7:0]  d3_up_addr;
    logic [31:0] d3_up_data_wr;
    logic [31:0] d3_up_data_rd = 32'h0BAD_F00D;

    always #5 clk = ~clk;

    ha1588_bus_arb #(.ADDR_W(8), .DATA_W(32), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .up_wr(up_wr), .up_rd(up_rd), .up_addr(up_addr), .up_data_wr(up_data_wr),
        .up_data_rd(up_data_rd), .busy(busy)
    );

    ha1588_bus_arb #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata), .m0_lock(d3_zero),
        .m0_gnt(d3_m0_gnt), .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_zero), .m1_we(d3_zero), .m1_addr(d3_zaddr), .m1_wdata(d3_zdata), .m1_lock(d3_zero),
        .m1_gnt(d3_m1_gnt), .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .up_wr(d3_up_wr), .up_rd(d3_up_rd), .up_addr(d3_up_addr), .up_data_wr(d3_up_data_wr),
        .up_data_rd(d3_up_data_rd), .busy(d3_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] core_val(input logic [7:0] a);
        return 32'h1234_5678 ^ {24'h0, a} ^ {8'h0, a, 16'h0};
    endfunction

    function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [31:0] d, input logic lk);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.lock = lk;
        return t;
    endfunction

    // ---------------- requester drivers ----------------
    txn_t q0[$];
    txn_t q1[$];

    initial begin
        bit p0, p1;
        p0 = 1'b0; p1 = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                p0 = 1'b0; p1 = 1'b0;
            end else begin
                if (p0 && q0.size() > 0) void'(q0.pop_front());
                if (p1 && q1.size() > 0) void'(q1.pop_front());
                p0 = 1'b0; p1 = 1'b0;
            end
            if (!rst && q0.size() > 0) begin
                m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr;
                m0_wdata = q0[0].wdata; m0_lock = q0[0].lock;
            end else begin
                m0_req = 1'b0; m0_lock = 1'b0;
            end
            if (!rst && q1.size() > 0) begin
                m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr;
                m1_wdata = q1[0].wdata; m1_lock = q1[0].lock;
            end else begin
                m1_req = 1'b0; m1_lock = 1'b0;
            end
            p0 = !rst && m0_ack;
            p1 = !rst && m1_ack;
        end
    end

    // ---------------- core model: data valid exactly LAT cycles after up_rd ----------------
    int         rd_due = -1;
    logic [7:0] rd_addr = '0;

    always @(negedge clk) begin
        if (rst) rd_due = -1;
        else if (up_rd) begin
            rd_due  = cyc + int'(LAT);
            rd_addr = up_addr;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        up_data_rd = (!rst && cyc == rd_due) ? core_val(rd_addr) : 32'hDEAD_BEEF;
    end

    // ---------------- transaction-schedule model ----------------
    bit          m_active = 0, m_owner = 0, m_we = 0, m_prio = 0, m_locked = 0, m_lock_owner = 0;
    logic [7:0]  m_addr = '0;
    int          m_issue = 0, m_ack = 0, m_next_arb = 0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_rdata0 = '0, e_rdata1 = '0;

    task mdl_reset();
        m_active = 0; m_prio = 0; m_locked = 0; m_lock_owner = 0;
        m_next_arb = 0; e_addr = '0; e_wdata = '0; e_rdata0 = '0; e_rdata1 = '0;
    endtask

    always @(posedge rst) mdl_reset();

    always @(posedge clk) begin
        bit r0, r1, lk;
        cyc = cyc + 1;
        if (rst) mdl_reset();
        else begin
            if (m_active && cyc == m_ack + 1) begin
                lk = m_owner ? m1_lock : m0_lock;
                m_locked = lk;
                m_lock_owner = m_owner;
                if (!lk) m_prio = !m_owner;
                m_active = 0;
                m_next_arb = cyc + 1;
            end else if (!m_active && cyc >= m_next_arb) begin
                r0 = m0_req && !(m_locked && m_lock_owner);
                r1 = m1_req && !(m_locked && !m_lock_owner);
                if (r0 || r1) begin
                    m_owner  = (r0 && r1) ? m_prio : r1;
                    m_we     = m_owner ? m1_we : m0_we;
                    m_addr   = m_owner ? m1_addr : m0_addr;
                    e_addr   = m_addr;
                    e_wdata  = m_owner ? m1_wdata : m0_wdata;
                    m_active = 1;
                    m_issue  = cyc;
                    m_ack    = cyc + (m_we ? 1 : int'(LAT) + 1);
                end
            end
            if (m_active && cyc == m_ack && !m_we) begin
                if (m_owner) e_rdata1 = core_val(m_addr);
                else         e_rdata0 = core_val(m_addr);
            end
        end
    end

    // Every-cycle comparison of all RD_LAT=1 outputs against the model.
    always @(negedge clk) begin : cmp
        logic e_g0, e_g1, e_a0, e_a1, e_wr, e_rd;
        e_g0 = (m_active && !m_owner) || (m_locked && !m_lock_owner);
        e_g1 = (m_active &&  m_owner) || (m_locked &&  m_lock_owner);
        e_a0 = m_active && cyc == m_ack && !m_owner;
        e_a1 = m_active && cyc == m_ack &&  m_owner;
        e_wr = m_active && cyc == m_issue &&  m_we;
        e_rd = m_active && cyc == m_issue && !m_we;
        chk("m0_gnt", m0_gnt, e_g0);
        chk("m1_gnt", m1_gnt, e_g1);
        chk("m0_ack", m0_ack, e_a0);
        chk("m1_ack", m1_ack, e_a1);
        chk("up_wr", up_wr, e_wr);
        chk("up_rd", up_rd, e_rd);
        chk("up_addr", up_addr, e_addr);
        chk("up_data_wr", up_data_wr, e_wdata);
        chk("m0_rdata", m0_rdata, e_rdata0);
        chk("m1_rdata", m1_rdata, e_rdata1);
        chk("busy", busy, m_active);
    end

    // ---------------- event log for literal checks ----------------
    int          is_cyc[$], is_own[$], is_wr[$];
    logic [7:0]  is_addr[$];
    logic [31:0] is_wd[$];
    int          ak_cyc[$], ak_own[$];
    logic [31:0] ak_rd[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (up_wr || up_rd) begin
                is_cyc.push_back(cyc);
                is_own.push_back(m0_gnt ? 0 : (m1_gnt ? 1 : 2));
                is_wr.push_back(int'(up_wr));
                is_addr.push_back(up_addr);
                is_wd.push_back(up_data_wr);
            end
            if (m0_ack) begin ak_cyc.push_back(cyc); ak_own.push_back(0); ak_rd.push_back(m0_rdata); end
            if (m1_ack) begin ak_cyc.push_back(cyc); ak_own.push_back(1); ak_rd.push_back(m1_rdata); end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_active || m0_req || m1_req) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_quiet: traffic still pending after %0d cycles", budget);
        end
        repeat (2) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bi, ba, k, acks;
        int ord3[8];
        int ord4[6];
        logic [7:0] adr4[6];
        ord3 = '{0, 1, 0, 1, 0, 1, 0, 1};
        ord4 = '{1, 1, 1, 1, 0, 0};
        adr4 = '{8'h30, 8'h34, 8'h38, 8'h3C, 8'h60, 8'h64};

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_up_addr", up_addr, 0);
        chk("reset_gnt", {m1_gnt, m0_gnt}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // single write by m0
        bi = is_cyc.size(); ba = ak_cyc.size();
        q0.push_back(mk(1'b1, 8'h10, 32'h0000_00A5, 1'b0));
        wait_quiet(50);
        chk("wr_issue_count", is_cyc.size() - bi, 1);
        chk("wr_owner", is_own[bi], 0);
        chk("wr_strobe_is_write", is_wr[bi], 1);
        chk("wr_addr", is_addr[bi], 8'h10);
        chk("wr_data", is_wd[bi], 32'h0000_00A5);
        chk("wr_ack_owner", ak_own[ba], 0);
        chk("wr_ack_latency", ak_cyc[ba] - is_cyc[bi], 1);

        // single read by m1
        bi = is_cyc.size(); ba = ak_cyc.size();
        q1.push_back(mk(1'b0, 8'h00, 32'h0, 1'b0));
        wait_quiet(50);
        chk("rd_owner", is_own[bi], 1);
        chk("rd_strobe_is_read", is_wr[bi], 0);
        chk("rd_ack_owner", ak_own[ba], 1);
        chk("rd_rdata", ak_rd[ba], 32'h1234_5678);
        chk("rd_ack_latency", ak_cyc[ba] - is_cyc[bi], 2);

        // both request continuously from reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bi = is_cyc.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b1, 8'(8'h20 + i), 32'(32'hA000 + i), 1'b0));
            q1.push_back(mk(1'b1, 8'(8'h28 + i), 32'(32'hB000 + i), 1'b0));
        end
        wait_quiet(100);
        chk("rr_issue_count", is_cyc.size() - bi, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("rr_order[%0d]", i), is_own[bi + i], ord3[i]);
        for (int i = 1; i < 8; i++) chk($sformatf("wr_spacing[%0d]", i), is_cyc[bi + i] - is_cyc[bi + i - 1], 3);

        // m1 locked read burst while m0 waits
        bi = is_cyc.size();
        q1.push_back(mk(1'b0, 8'h30, 32'h0, 1'b1));
        q1.push_back(mk(1'b0, 8'h34, 32'h0, 1'b1));
        q1.push_back(mk(1'b0, 8'h38, 32'h0, 1'b1));
        q1.push_back(mk(1'b0, 8'h3C, 32'h0, 1'b0));
        tick();
        q0.push_back(mk(1'b1, 8'h60, 32'hC000, 1'b0));
        q0.push_back(mk(1'b1, 8'h64, 32'hC001, 1'b0));
        wait_quiet(100);
        chk("lock_issue_count", is_cyc.size() - bi, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lock_order[%0d]", i), is_own[bi + i], ord4[i]);
            chk($sformatf("lock_addr[%0d]", i), is_addr[bi + i], adr4[i]);
        end
        for (int i = 1; i < 4; i++) chk($sformatf("rd_spacing[%0d]", i), is_cyc[bi + i] - is_cyc[bi + i - 1], 4);

        // reset during WAIT abandons the read
        bi = is_cyc.size(); ba = ak_cyc.size();
        q0.push_back(mk(1'b0, 8'h44, 32'h0, 1'b0));
        k = 0;
        while (is_cyc.size() == bi && k < 20) begin tick(); k++; end
        chk("abort_read_issued", is_cyc.size() - bi, 1);
        tick();
        rst = 1'b1;
        q0.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_gnt", {m1_gnt, m0_gnt}, 0);
        chk("abort_ack", {m1_ack, m0_ack}, 0);
        chk("abort_up_addr", up_addr, 0);
        chk("abort_m1_rdata", m1_rdata, 0);
        repeat (2) tick();
        rst = 1'b0;
        q0.push_back(mk(1'b0, 8'h48, 32'h0, 1'b0));
        wait_quiet(50);
        chk("after_reset_issue_count", is_cyc.size() - bi, 2);
        chk("after_reset_ack_count", ak_cyc.size() - ba, 1);
        chk("after_reset_rdata", ak_rd[ba], 32'h127C_5630);
        chk("after_reset_latency", ak_cyc[ba] - is_cyc[bi + 1], 2);

        // RD_LAT=3 instance: req dropped during WAIT, ack still once
        d3_m0_we = 1'b0; d3_m0_addr = 8'h50; d3_m0_req = 1'b1;
        k = 0;
        while (!d3_up_rd && k < 20) begin tick(); k++; end
        chk("d3_up_rd_seen", d3_up_rd, 1);
        chk("d3_up_addr", d3_up_addr, 8'h50);
        acks = 0;
        tick(); d3_m0_req = 1'b0; acks += int'(d3_m0_ack);
        tick(); acks += int'(d3_m0_ack);
        tick(); acks += int'(d3_m0_ack); d3_up_data_rd = 32'hCAFE_0050;
        tick();
        chk("d3_ack_lat_plus1", d3_m0_ack, 1);
        chk("d3_rdata", d3_m0_rdata, 32'hCAFE_0050);
        d3_up_data_rd = 32'h0BAD_F00D;
        repeat (6) begin tick(); acks += int'(d3_m0_ack); end
        chk("d3_extra_acks", acks, 0);
        chk("d3_busy_end", d3_busy, 0);
        chk("d3_rdata_held", d3_m0_rdata, 32'hCAFE_0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ha1588_bus_arb.md
HA1588_BUS_ARB -- requirements
Module: ha1588_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning local bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning local bus data width.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..7, meaning cycles from up_rd strobe to valid up_data_rd.
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have, per requester N in {0,1}, port mN_req, input, 1, meaning transaction request, held high until mN_ack.
REQ-007 SHALL have, per N, port mN_we, input, 1, meaning 1 = write, 0 = read; stable while mN_req is high.
REQ-008 SHALL have, per N, port mN_addr, input, ADDR_W, meaning register address; stable while mN_req is high.
REQ-009 SHALL have, per N, port mN_wdata, input, DATA_W, meaning write data; stable while mN_req is high.
REQ-010 SHALL have, per N, port mN_lock, input, 1, meaning keep the grant after ack for an atomic sequence.
REQ-011 SHALL have, per N, port mN_gnt, output, 1, meaning requester N owns the bus.
REQ-012 SHALL have, per N, port mN_ack, output, 1, meaning one-cycle completion pulse.
REQ-013 SHALL have, per N, port mN_rdata, output, DATA_W, meaning read data, valid in the mN_ack cycle and held until the next read by N.
REQ-014 SHALL have port up_wr, output, 1, meaning a one-cycle write strobe to the ha1588 core.
REQ-015 SHALL have port up_rd, output, 1, meaning a one-cycle read strobe to the core.
REQ-016 SHALL have ports up_addr (output, ADDR_W), up_data_wr (output, DATA_W) and up_data_rd (input, DATA_W), meaning the core address, write data and read data.
REQ-017 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-018 SHALL use FSM states IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE, with any mN_req high, SHALL grant the requester selected by arbitration, register its we, addr and wdata, and go to ISSUE.
REQ-020 SHALL arbitrate round-robin: when both request, the priority holder wins; after an unlocked completion, priority passes to the other requester.
REQ-021 While the owner's mN_lock is high at ack, SHALL keep mN_gnt and consider only that requester, not the other, until the owner completes a transaction with lock low.
REQ-022 In ISSUE, SHALL assert exactly one of up_wr or up_rd for one cycle, with up_addr and up_data_wr driven from the registered values.
REQ-023 For a write, ISSUE SHALL go to DONE; mN_ack SHALL pulse in DONE, one cycle after up_wr.
REQ-024 For a read, ISSUE SHALL go to WAIT, which holds for RD_LAT cycles and samples up_data_rd on its last cycle; DONE SHALL then present mN_rdata and pulse mN_ack, RD_LAT+1 cycles after up_rd.
REQ-025 DONE SHALL always return to IDLE, giving at least one idle cycle between transactions.
REQ-026 Write throughput SHALL be one transaction per 3 cycles; read throughput one per RD_LAT+3 cycles.
REQ-027 If mN_req drops before ack (protocol violation), the transaction in flight SHALL complete and ack SHALL still pulse; no abort.
REQ-028 When not in ISSUE, up_wr and up_rd SHALL be 0; up_addr and up_data_wr SHALL hold their last values.
REQ-029 mN_gnt SHALL be high from the ISSUE cycle through DONE, or continuously while locked; mN_gnt SHALL never be high for both requesters at once.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Asserting rst SHALL asynchronously force: state IDLE; priority to m0; lock cleared; all strobes, gnt, ack and busy to 0; up_addr, up_data_wr and mN_rdata to 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ack; the first request after release SHALL be served normally.

Structure
REQ-033 The FSM state encoding and the RD_LAT maximum SHALL live in a shared package, ha1588_pkg.
REQ-034 The block SHALL be flat except for one natural sub-module, ha1588_rr_arb: a 2-way round-robin picker with a lock input.

Verification
REQ-035 Single write: m0 writes addr 0x10, data 0x0000_00A5 -> up_wr high 1 cycle with those values; m0_ack exactly 1 cycle later.
REQ-036 Single read with RD_LAT=1: the core returns 0x1234_5678 -> m1_ack and m1_rdata = 0x1234_5678 two cycles after up_rd.
REQ-037 Both requesters request continuously from reset -> grants alternate m0, m1, m0, m1, with the first grant to m0.
REQ-038 m1 lock high over 4 reads (addr 0x30..0x3C) while m0 requests -> m0 is not granted until after m1's lock-low completion.
REQ-039 rst pulsed during WAIT -> no ack, all outputs 0; a new m0 read after release completes with the correct latency.
REQ-040 RD_LAT=3 read -> ack 4 cycles after up_rd; m0_req dropped in WAIT -> ack still pulses once.
